// File: rtl/fetch_queue.sv
// fetch_queue: PC generator, instruction-RAM request port and prefetch FIFO
// with a valid/ready handshake to decode.
//
// Requests are issued against a credit that counts queued entries plus
// in-flight RAM reads. The FIFO can therefore never overflow, whatever the
// RAM latency or decode back-pressure.
//
// A redirect flushes the queue and drops any returning data. Requests restart
// from the new PC on the following cycle.
//
// Optional feature, macro FETCH_MISALIGN_CHK_EN:
//   A redirect to a target that is not word-aligned halts fetch and raises
//   oMisalign. The halt holds until the next aligned redirect or reset.
//   Without the macro, the redirect target's low two bits are forced to zero
//   and oMisalign is tied low.
module fetch_queue #(
  parameter int unsigned       cXLEN       = 32,
  parameter int unsigned       cAddrW      = 10,
  parameter int unsigned       cFifoDepth  = 4,
  parameter int unsigned       cRamLatency = 1,
  parameter logic [cXLEN-1:0]  cResetPc    = '0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iRedirectValid,
  input  logic [cXLEN-1:0]  iRedirectPc,
  input  logic              iInstrReady,
  output logic              oInstrValid,
  output logic [cXLEN-1:0]  oInstr,
  output logic [cXLEN-1:0]  oCurPc,
  output logic              oMemEn,
  output logic [cAddrW-1:0] oMemAddr,
  input  logic [cXLEN-1:0]  iMemData,
  output logic              oMisalign
);

  localparam int unsigned cPtrW  = $clog2(cFifoDepth);
  localparam int unsigned cCntW  = $clog2(cFifoDepth + 1);
  localparam int unsigned cCredW = $clog2(cFifoDepth + cRamLatency + 1) + 1;

  if (((cFifoDepth & (cFifoDepth - 1)) != 0) || (cFifoDepth < cRamLatency + 1) ||
      (cRamLatency < 1) || (cRamLatency > 4) || (cAddrW + 2 > cXLEN)) begin : g_cfg_err
    $error("fetch_queue: illegal cFifoDepth/cRamLatency/cAddrW combination");
  end

  // Architectural state
  logic [cXLEN-1:0]       r_fetch_pc;
  logic [cRamLatency-1:0] r_trk_vld;
  logic [cXLEN-1:0]       r_trk_pc [cRamLatency];
  logic [cXLEN-1:0]       r_fifo_data [cFifoDepth];
  logic [cXLEN-1:0]       r_fifo_pc [cFifoDepth];
  logic [cPtrW-1:0]       r_rd_ptr;
  logic [cPtrW-1:0]       r_wr_ptr;
  logic [cCntW-1:0]       r_count;

  logic [cXLEN-1:0]  w_redir_pc;
  logic              w_halt;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [cCredW-1:0] w_inflight;
  logic [cCredW-1:0] w_occ;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_halt;

  // Halt on a misaligned redirect target; any aligned redirect resumes fetch
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_halt <= 1'b0;
    end else if (iRedirectValid) begin
      r_halt <= (iRedirectPc[1:0] != 2'b00);
    end
  end

  assign w_redir_pc = iRedirectPc;
  assign w_halt     = r_halt;
`else
  assign w_redir_pc = iRedirectPc & ~cXLEN'(3);
  assign w_halt     = 1'b0;
`endif

  assign oMisalign = w_halt;

  // Count tracker stages holding a live request
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < int'(cRamLatency); i++) begin
      w_inflight = w_inflight + cCredW'(r_trk_vld[i]);
    end
  end

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & iInstrReady;
  assign w_push  = r_trk_vld[cRamLatency-1];
  assign w_occ   = cCredW'(r_count) + w_inflight;
  // credit = depth - occ + pop > 0; reset gating keeps oMemEn low while iRst is high
  assign w_issue = !iRst && !iRedirectValid && !w_halt &&
                   ((w_occ < cCredW'(cFifoDepth)) || w_pop);

  assign oMemEn      = w_issue;
  assign oMemAddr    = w_issue ? r_fetch_pc[cAddrW+1:2] : '0;
  assign oInstrValid = w_valid;
  assign oInstr      = w_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign oCurPc      = w_valid ? r_fifo_pc[r_rd_ptr] : '0;

  // Fetch PC: redirect wins, otherwise step one word per issued request
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_fetch_pc <= cResetPc;
    end else if (iRedirectValid) begin
      r_fetch_pc <= w_redir_pc;
    end else if (w_issue) begin
      r_fetch_pc <= r_fetch_pc + cXLEN'(4);
    end
  end

  // In-flight tracker: one stage per RAM latency cycle, cleared by redirect
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_trk_vld <= '0;
      for (int i = 0; i < int'(cRamLatency); i++) begin
        r_trk_pc[i] <= '0;
      end
    end else begin
      r_trk_vld[0] <= w_issue;
      r_trk_pc[0]  <= r_fetch_pc;
      for (int i = 1; i < int'(cRamLatency); i++) begin
        r_trk_vld[i] <= r_trk_vld[i-1] & ~iRedirectValid;
        r_trk_pc[i]  <= r_trk_pc[i-1];
      end
    end
  end

  // Prefetch FIFO: push from the exiting tracker stage, pop on decode handshake
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(cFifoDepth); i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (iRedirectValid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= iMemData;
        r_fifo_pc[r_wr_ptr]   <= r_trk_pc[cRamLatency-1];
        r_wr_ptr              <= r_wr_ptr + cPtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + cPtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cCntW'(1);
        2'b01:   r_count <= r_count - cCntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue. Two instances share stimulus: latency 1 and latency 3,
// both with depth 4. A transaction-level model (queued entries, in-flight reads with
// ages) predicts every output each cycle; literal checks pin key test-plan points.
module tb_fetch_queue;

  localparam int unsigned AW    = 10;
  localparam int          DEPTH = 4;
  localparam int          LAT_A = 1;
  localparam int          LAT_B = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        redir;
  logic [31:0] redir_pc;
  logic        ready;

  logic          o_valid [2];
  logic [31:0]   o_instr [2];
  logic [31:0]   o_curpc [2];
  logic          o_en    [2];
  logic [AW-1:0] o_addr  [2];
  logic [31:0]   mem_data[2];
  logic          o_mis   [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_queue #(.cXLEN(32), .cAddrW(AW), .cFifoDepth(DEPTH), .cRamLatency(LAT_A),
                .cResetPc(32'h0)) u_dut_a (
    .iClk(clk), .iRst(rst), .iRedirectValid(redir), .iRedirectPc(redir_pc),
    .iInstrReady(ready), .oInstrValid(o_valid[0]), .oInstr(o_instr[0]),
    .oCurPc(o_curpc[0]), .oMemEn(o_en[0]), .oMemAddr(o_addr[0]),
    .iMemData(mem_data[0]), .oMisalign(o_mis[0])
  );

  fetch_queue #(.cXLEN(32), .cAddrW(AW), .cFifoDepth(DEPTH), .cRamLatency(LAT_B),
                .cResetPc(32'h0)) u_dut_b (
    .iClk(clk), .iRst(rst), .iRedirectValid(redir), .iRedirectPc(redir_pc),
    .iInstrReady(ready), .oInstrValid(o_valid[1]), .oInstr(o_instr[1]),
    .oCurPc(o_curpc[1]), .oMemEn(o_en[1]), .oMemAddr(o_addr[1]),
    .iMemData(mem_data[1]), .oMisalign(o_mis[1])
  );

  function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
    return 32'h1000 + {22'b0, a};
  endfunction

  // RAM: RAM[i] = 0x1000 + i, returned a fixed latency after the request
  logic [31:0] pipe [2][4];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe[k][0] <= o_en[k] ? ram_word(o_addr[k]) : (32'hBAD0_0000 | 32'(k));
      for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
    end
  end
  assign mem_data[0] = pipe[0][LAT_A-1];
  assign mem_data[1] = pipe[1][LAT_B-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_fpc [2][8];
  logic [31:0] m_fdat[2][8];
  int          m_fcnt[2];
  logic [31:0] m_ipc [2][8];
  int          m_iage[2][8];
  int          m_icnt[2];
  logic [31:0] m_pc  [2];
  bit          m_halt[2];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic bit exp_pop(input int k);
    return !rst && !redir && (m_fcnt[k] != 0) && ready;
  endfunction

  function automatic bit exp_issue(input int k);
    int credit;
    credit = DEPTH - m_fcnt[k] - m_icnt[k] + ((m_fcnt[k] != 0 && ready) ? 1 : 0);
    return !rst && !redir && !m_halt[k] && (credit > 0);
  endfunction

  function automatic logic [31:0] tgt_of(input logic [31:0] p);
`ifdef FETCH_MISALIGN_CHK_EN
    return p;
`else
    return {p[31:2], 2'b00};
`endif
  endfunction

  function automatic bit halt_of(input logic [31:0] p);
`ifdef FETCH_MISALIGN_CHK_EN
    return p[1:0] != 2'b00;
`else
    return (p[1:0] != 2'b00) && 1'b0;
`endif
  endfunction

  initial begin : p_model
    bit iss;
    bit pp;
    int keep;
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_fcnt[k] = 0; m_icnt[k] = 0; m_pc[k] = 32'h0; m_halt[k] = 1'b0;
        end else if (redir) begin
          m_fcnt[k] = 0; m_icnt[k] = 0;
          m_pc[k]   = tgt_of(redir_pc);
          m_halt[k] = halt_of(redir_pc);
        end else begin
          iss = exp_issue(k);
          pp  = exp_pop(k);
          if (pp) begin
            for (int i = 1; i < m_fcnt[k]; i++) begin
              m_fpc[k][i-1]  = m_fpc[k][i];
              m_fdat[k][i-1] = m_fdat[k][i];
            end
            m_fcnt[k]--;
          end
          keep = 0;
          for (int i = 0; i < m_icnt[k]; i++) begin
            if (m_iage[k][i] == lat_of(k)) begin
              if (m_fcnt[k] < 8) begin
                m_fpc[k][m_fcnt[k]]  = m_ipc[k][i];
                m_fdat[k][m_fcnt[k]] = ram_word(m_ipc[k][i][AW+1:2]);
                m_fcnt[k]++;
              end
            end else begin
              m_ipc[k][keep]  = m_ipc[k][i];
              m_iage[k][keep] = m_iage[k][i] + 1;
              keep++;
            end
          end
          m_icnt[k] = keep;
          if (iss) begin
            m_ipc[k][keep]  = m_pc[k];
            m_iage[k][keep] = 1;
            m_icnt[k]++;
            m_pc[k] = m_pc[k] + 32'd4;
          end
        end
      end
    end
  end

  // Compare every output of both instances against the model, mid-cycle
  initial begin : p_cmp
    logic [31:0] e_instr, e_pc, e_addr;
    bit e_valid, e_en;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        e_valid = !rst && (m_fcnt[k] != 0);
        e_instr = e_valid ? m_fdat[k][0] : 32'h0;
        e_pc    = e_valid ? m_fpc[k][0] : 32'h0;
        e_en    = exp_issue(k);
        e_addr  = e_en ? {22'b0, m_pc[k][AW+1:2]} : 32'h0;
        check($sformatf("cmp_valid_%0d", k), 32'(o_valid[k]), 32'(e_valid));
        check($sformatf("cmp_instr_%0d", k), o_instr[k], e_instr);
        check($sformatf("cmp_curpc_%0d", k), o_curpc[k], e_pc);
        check($sformatf("cmp_memen_%0d", k), 32'(o_en[k]), 32'(e_en));
        check($sformatf("cmp_addr_%0d", k), 32'(o_addr[k]), e_addr);
        check($sformatf("cmp_misalign_%0d", k), 32'(o_mis[k]), 32'(m_halt[k] && !rst));
      end
    end
  end

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges; returns at start of cycle 0 after release
  task automatic do_reset(input logic rdy);
    rst = 1'b1; redir = 1'b0; ready = rdy;
    cyc_end();
    cyc_end();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : p_stim
    int n_en[2];
    int c;
    rst = 1'b1; redir = 1'b0; redir_pc = 32'h0; ready = 1'b0;
    #2;
    check("rst_valid_a", 32'(o_valid[0]), 32'h0);
    check("rst_en_a", 32'(o_en[0]), 32'h0);

    // Streaming from reset
    do_reset(1'b1);
    @(negedge clk);
    check("c0_en_a", 32'(o_en[0]), 32'h1);
    check("c0_addr_a", 32'(o_addr[0]), 32'h0);
    cyc_end(); cyc_end();
    @(negedge clk);
    check("c2_valid_a", 32'(o_valid[0]), 32'h1);
    check("c2_curpc_a", o_curpc[0], 32'h0);
    check("c2_instr_a", o_instr[0], 32'h1000);
    cyc_end();
    @(negedge clk);
    check("c3_curpc_a", o_curpc[0], 32'h4);
    check("c3_instr_a", o_instr[0], 32'h1001);
    cyc_end();
    @(negedge clk);
    check("c4_valid_b", 32'(o_valid[1]), 32'h1);
    check("c4_curpc_b", o_curpc[1], 32'h0);
    repeat (10) cyc_end();

    // Back-pressure from reset: exactly DEPTH requests, then drain without gaps
    do_reset(1'b0);
    n_en = '{0, 0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) n_en[k] += int'(o_en[k]);
      cyc_end();
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("stall_reqs_%0d", k), 32'(n_en[k]), 32'd4);
      check($sformatf("stall_head_%0d", k), o_curpc[k], 32'h0);
      check($sformatf("stall_en_%0d", k), 32'(o_en[k]), 32'h0);
    end
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("drain_valid_%0d_%0d", k, i), 32'(o_valid[k]), 32'h1);
        check($sformatf("drain_pc_%0d_%0d", k, i), o_curpc[k], 32'(4 * i));
      end
      cyc_end();
    end

    // Redirect with two queued entries and one in flight (latency-1 instance)
    do_reset(1'b0);
    cyc_end(); cyc_end(); cyc_end();
    redir = 1'b1; redir_pc = 32'h40;
    @(negedge clk);
    check("redir_head_a", o_curpc[0], 32'h0);
    check("redir_en_a", 32'(o_en[0]), 32'h0);
    cyc_end();
    redir = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("redir_t1_en_a", 32'(o_en[0]), 32'h1);
    check("redir_t1_addr_a", 32'(o_addr[0]), 32'h10);
    check("redir_t1_valid_a", 32'(o_valid[0]), 32'h0);
    cyc_end();
    @(negedge clk);
    check("redir_t2_valid_a", 32'(o_valid[0]), 32'h0);
    cyc_end();
    @(negedge clk);
    check("redir_t3_curpc_a", o_curpc[0], 32'h40);
    check("redir_t3_instr_a", o_instr[0], 32'h1010);
    repeat (5) cyc_end();

    // Address wrap at the end of the RAM
    redir = 1'b1; redir_pc = 32'hFFC; ready = 1'b1;
    cyc_end();
    redir = 1'b0;
    @(negedge clk);
    check("wrap_addr0_b", 32'(o_addr[1]), 32'h3FF);
    cyc_end();
    @(negedge clk);
    check("wrap_addr1_b", 32'(o_addr[1]), 32'h000);
    check("wrap_en1_b", 32'(o_en[1]), 32'h1);
    cyc_end(); cyc_end(); cyc_end();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("wrap_valid_b_%0d", i), 32'(o_valid[1]), 32'h1);
      check($sformatf("wrap_pc_b_%0d", i), o_curpc[1], 32'hFFC + 32'(4 * i));
      cyc_end();
    end

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      ready    = ($urandom_range(0, 3) != 0);
      redir    = ($urandom_range(0, 15) == 0);
      redir_pc = $urandom;
      if ($urandom_range(0, 3) != 0) redir_pc[1:0] = 2'b00;
      cyc_end();
    end
    redir = 1'b0;

    // Asynchronous reset with three entries queued
    do_reset(1'b0);
    c = 0;
    while (c < 4) begin cyc_end(); c++; end
    check("pre_arst_valid_a", 32'(o_valid[0]), 32'h1);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("arst_valid_%0d", k), 32'(o_valid[k]), 32'h0);
      check($sformatf("arst_instr_%0d", k), o_instr[k], 32'h0);
      check($sformatf("arst_curpc_%0d", k), o_curpc[k], 32'h0);
      check($sformatf("arst_en_%0d", k), 32'(o_en[k]), 32'h0);
      check($sformatf("arst_addr_%0d", k), 32'(o_addr[k]), 32'h0);
      check($sformatf("arst_mis_%0d", k), 32'(o_mis[k]), 32'h0);
    end
    do_reset(1'b1);
    @(negedge clk);
    check("rst2_addr_a", 32'(o_addr[0]), 32'h0);
    check("rst2_en_a", 32'(o_en[0]), 32'h1);
    cyc_end(); cyc_end();
    @(negedge clk);
    check("rst2_curpc_a", o_curpc[0], 32'h0);
    check("rst2_instr_a", o_instr[0], 32'h1000);
    repeat (4) cyc_end();

    // Misaligned redirect
    redir = 1'b1; redir_pc = 32'h42;
    cyc_end();
    redir = 1'b0;
    @(negedge clk);
`ifdef FETCH_MISALIGN_CHK_EN
    check("mis_flag_a", 32'(o_mis[0]), 32'h1);
    check("mis_en_a", 32'(o_en[0]), 32'h0);
    cyc_end(); cyc_end();
    check("mis_hold_valid_a", 32'(o_valid[0]), 32'h0);
    redir = 1'b1; redir_pc = 32'h80;
    @(negedge clk);
    check("mis_hold_flag_a", 32'(o_mis[0]), 32'h1);
    cyc_end();
    redir = 1'b0;
    @(negedge clk);
    check("mis_clr_flag_a", 32'(o_mis[0]), 32'h0);
    check("mis_clr_en_a", 32'(o_en[0]), 32'h1);
    check("mis_clr_addr_a", 32'(o_addr[0]), 32'h20);
    cyc_end(); cyc_end();
    @(negedge clk);
    check("mis_resume_pc_a", o_curpc[0], 32'h80);
    check("mis_resume_instr_a", o_instr[0], 32'h1020);
`else
    check("mis_flag_a", 32'(o_mis[0]), 32'h0);
    check("mis_addr_a", 32'(o_addr[0]), 32'h10);
    cyc_end(); cyc_end();
    @(negedge clk);
    check("mis_forced_pc_a", o_curpc[0], 32'h40);
`endif
    repeat (5) cyc_end();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
